spi_tx: RTL and testbench

- SPI master transmitter that drives SS_n, SCLK and MOSI for one 8- or 16-bit word per request.
- Counterpart of the capture-side SPI receiver and protocol trigger.
- Used as an on-chip stimulus generator and loop-back source for self-test of the SPI trigger path.
- Bit order and sample-edge modes match what the SPI receiver accepts.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_tx_if.sv | 30 +++
 rtl/spi_tx_tick.sv | 30 +++
 rtl/spi_tx.sv | 137 +++++++++++++
 tb/tb_spi_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI transmitter
package spi_pkg;

  // Maximum word width carried by one request.
  localparam int CMD_W = 16;

  // SCLK toggle counts per word: two toggles per bit.
  localparam int TOG_8  = 16;
  localparam int TOG_16 = 32;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spiState_t;

endpackage

// File: rtl/spi_tx_if.sv
// rtl/spi_tx_if.sv - request and SPI pin bundle for the SPI transmitter
interface spi_tx_if;
  import spi_pkg::*;

  // Request side
  logic             wrt;
  logic [CMD_W-1:0] cmd;
  logic             len8;
  logic             pos_edge;

  // SPI pins and status
  logic             SS_n;
  logic             SCLK;
  logic             MOSI;
  logic             busy;
  logic             done;

  // Requester / observer side
  modport master (
    output wrt, cmd, len8, pos_edge,
    input  SS_n, SCLK, MOSI, busy, done
  );

  // Transmitter side
  modport slave (
    input  wrt, cmd, len8, pos_edge,
    output SS_n, SCLK, MOSI, busy, done
  );

endinterface

// File: rtl/spi_tx_tick.sv
// rtl/spi_tx_tick.sv - SCLK half-period tick generator
module spi_tx_tick #(
  parameter int SCLK_HALF = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCLK_HALF - 1);

  logic [CW-1:0] cnt;

  // A tick marks the last cycle of each half-period while enabled.
  assign tick = en && (cnt == TERM);

  // Count half-period cycles; hold at zero while disabled so every enable starts a full half-period.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - SPI master transmitter, one 8- or 16-bit word per request
module spi_tx
  import spi_pkg::*;
#(
  parameter int SCLK_HALF = 10
) (
  input  logic     clk,
  input  logic     rst,
  spi_tx_if.slave  spi
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_FRONT = FRONT;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_BACK  = BACK;

  logic [1:0]       state;
  logic [CMD_W-1:0] shiftReg;
  logic [4:0]       togCnt;
  logic [4:0]       lastTog;
  logic             len8Q;
  logic             posQ;
  logic             ssN;
  logic             sclkQ;
  logic             busyQ;
  logic             doneQ;

  logic             tick;
  logic             tickEn;
  logic             accept;
  logic             firstFall;
  logic             lastToggle;
  logic             shiftToggle;
  logic             shiftNow;
  logic             finish;

  // The half-period timer runs for the whole time slave select is low.
  assign tickEn = (state != ST_IDLE);

  spi_tx_tick #(
    .SCLK_HALF (SCLK_HALF)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tickEn),
    .tick (tick)
  );

  // The first fall is issued as FRONT ends; SHIFT issues the remaining toggles,
  // togCnt counting them so 5 bits cover the 32-toggle word.
  assign lastTog     = len8Q ? 5'(TOG_8 - 1) : 5'(TOG_16 - 1);
  assign accept      = (state == ST_IDLE) && spi.wrt;
  assign firstFall   = (state == ST_FRONT) && tick;
  assign lastToggle  = (togCnt == lastTog);
  assign shiftToggle = (state == ST_SHIFT) && tick && !lastToggle;
  assign finish      = (state == ST_BACK) && tick;

  // Shift on the edge opposite the receiver's sample edge: falls when it samples
  // on rises (the FRONT fall never shifts), rises when it samples on falls.
  assign shiftNow    = shiftToggle && (sclkQ ? posQ : !posQ);

  // Transfer sequencing: IDLE -> FRONT -> SHIFT -> BACK -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (spi.wrt)                state <= ST_FRONT;
        ST_FRONT: if (tick)                   state <= ST_SHIFT;
        ST_SHIFT: if (tick && lastToggle)     state <= ST_BACK;
        ST_BACK:  if (tick)                   state <= ST_IDLE;
        default:                              state <= ST_IDLE;
      endcase
    end
  end

  // Count SCLK toggles issued inside SHIFT.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      togCnt <= '0;
    end else if (shiftToggle) begin
      togCnt <= togCnt + 5'd1;
    end
  end

  // Capture the word format at acceptance so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      len8Q <= 1'b0;
      posQ  <= 1'b0;
    end else if (accept) begin
      len8Q <= spi.len8;
      posQ  <= spi.pos_edge;
    end
  end

  // Load the word MSB-aligned and move it left one bit per shift edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      shiftReg <= '0;
    end else if (accept) begin
      shiftReg <= spi.len8 ? {spi.cmd[7:0], 8'h00} : spi.cmd;
    end else if (shiftNow) begin
      shiftReg <= {shiftReg[CMD_W-2:0], 1'b0};
    end
  end

  // Registered pins: select, clock, busy and the end-of-word pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ssN   <= 1'b1;
      sclkQ <= 1'b1;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      doneQ <= finish;
      if (accept) begin
        ssN   <= 1'b0;
        busyQ <= 1'b1;
      end
      if (firstFall || shiftToggle) begin
        sclkQ <= ~sclkQ;
      end
      if (finish) begin
        ssN   <= 1'b1;
        busyQ <= 1'b0;
      end
    end
  end

  assign spi.SS_n = ssN;
  assign spi.SCLK = sclkQ;
  assign spi.MOSI = shiftReg[CMD_W-1];
  assign spi.busy = busyQ;
  assign spi.done = doneQ;

endmodule

// File: tb/tb_spi_tx.sv
// tb/tb_spi_tx.sv - self-checking bench for spi_tx
module tb_spi_tx;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_tx_if bus ();

  spi_tx #(
    .SCLK_HALF (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .spi (bus)
  );

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        pos;
    int          lowCycles;
  } exp_t;

  typedef struct {
    logic [15:0] cmd;
    logic        len8;
    logic        pos;
    logic [15:0] expWord;
    int          expLow;
  } vec_t;

  exp_t expQ[$];

  int checks    = 0;
  int errors    = 0;
  int doneCount = 0;

  // receiver-side model state
  logic        prevSclk = 1'b1;
  logic        prevSs   = 1'b1;
  logic        prevMosi = 1'b0;
  logic        prevDone = 1'b0;
  logic [15:0] word     = '0;
  int          rises    = 0;
  int          falls    = 0;
  int          lowCnt   = 0;
  int          mosiAge  = 100;
  int          sampleAge = 100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clearAcc();
    word   = '0;
    rises  = 0;
    falls  = 0;
    lowCnt = 0;
  endtask

  task automatic sampleBit(input string name);
    word = {word[14:0], bus.MOSI};
    chk(name, (mosiAge >= 5), 1'b1);
    sampleAge = 0;
  endtask

  // Receiver model: samples MOSI on the selected edge and scores each word at done.
  always @(negedge clk) begin
    exp_t e;
    logic curPos;
    if (rst === 1'b1) begin
      clearAcc();
    end else begin
      if (bus.MOSI !== prevMosi) begin
        if (!prevSs && !bus.SS_n) chk("mosi_hold_after_sample", (sampleAge >= 5), 1'b1);
        mosiAge = 0;
      end else begin
        mosiAge++;
      end
      sampleAge++;
      curPos = (expQ.size() > 0) ? expQ[0].pos : 1'b1;
      if (!bus.SS_n) begin
        lowCnt++;
        if (bus.done) chk("done_while_selected", bus.done, 1'b0);
        if (prevSclk && !bus.SCLK) begin
          falls++;
          if (!curPos) sampleBit("mosi_setup_fall");
        end
        if (!prevSclk && bus.SCLK) begin
          rises++;
          if (curPos) sampleBit("mosi_setup_rise");
        end
      end else if (bus.done) begin
        chk("done_with_ss_rise", prevSs, 1'b0);
        chk("done_busy_low", bus.busy, 1'b0);
        chk("done_single_cycle", prevDone, 1'b0);
        if (expQ.size() == 0) begin
          chk("done_unexpected", expQ.size(), 1);
        end else begin
          e = expQ.pop_front();
          chk("stream_word", word, e.word);
          chk("sclk_rises", rises, e.nbits);
          chk("sclk_falls", falls, e.nbits);
          chk("ss_low_cycles", lowCnt, e.lowCycles);
        end
        doneCount++;
        clearAcc();
      end else begin
        clearAcc();
      end
    end
    prevSclk = bus.SCLK;
    prevSs   = bus.SS_n;
    prevMosi = bus.MOSI;
    prevDone = bus.done;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Drive one request now and check the one-cycle select latency.
  task automatic sendWord(input logic [15:0] cmd, input logic len8, input logic pos,
                          input logic [15:0] expWord, input int expLow);
    exp_t e;
    bus.wrt      = 1'b1;
    bus.cmd      = cmd;
    bus.len8     = len8;
    bus.pos_edge = pos;
    e.word       = expWord;
    e.nbits      = len8 ? 8 : 16;
    e.pos        = pos;
    e.lowCycles  = expLow;
    expQ.push_back(e);
    idle(1);
    bus.wrt      = 1'b0;
    bus.cmd      = ~cmd;
    bus.len8     = ~len8;
    bus.pos_edge = ~pos;
    chk("ss_low_latency", bus.SS_n, 1'b0);
    chk("busy_after_wrt", bus.busy, 1'b1);
    chk("first_bit", bus.MOSI, len8 ? cmd[7] : cmd[15]);
  endtask

  task automatic waitDone(input int bound, input string name);
    int start;
    int n;
    start = doneCount;
    n = 0;
    while (doneCount == start && n < bound) begin
      idle(1);
      n++;
    end
    chk({name, "_done_count"}, doneCount - start, 1);
  endtask

  task automatic chkResetPins(input string tag);
    chk({tag, "_SS_n"}, bus.SS_n, 1'b1);
    chk({tag, "_SCLK"}, bus.SCLK, 1'b1);
    chk({tag, "_MOSI"}, bus.MOSI, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
  endtask

  initial begin
    vec_t vecs[6];
    int start;

    bus.wrt      = 1'b0;
    bus.cmd      = '0;
    bus.len8     = 1'b0;
    bus.pos_edge = 1'b0;
    rst          = 1'b1;
    idle(3);
    chkResetPins("reset");
    rst = 1'b0;
    idle(2);
    chkResetPins("idle");

    vecs[0] = '{16'h5555, 1'b0, 1'b1, 16'h5555, 340};
    vecs[1] = '{16'h0444, 1'b0, 1'b0, 16'h0444, 340};
    vecs[2] = '{16'h3323, 1'b1, 1'b1, 16'h0023, 180};
    vecs[3] = '{16'hA5C3, 1'b1, 1'b0, 16'h00C3, 180};
    vecs[4] = '{16'h8001, 1'b0, 1'b1, 16'h8001, 340};
    vecs[5] = '{16'h7FFE, 1'b0, 1'b0, 16'h7FFE, 340};

    for (int i = 0; i < 6; i++) begin
      sendWord(vecs[i].cmd, vecs[i].len8, vecs[i].pos, vecs[i].expWord, vecs[i].expLow);
      waitDone(1000, "vector");
      idle(3);
    end

    // Request while busy is ignored; request in the done cycle is taken back-to-back.
    sendWord(16'hAAAA, 1'b0, 1'b1, 16'hAAAA, 340);
    idle(50);
    bus.wrt      = 1'b1;
    bus.cmd      = 16'hFFFF;
    bus.len8     = 1'b1;
    bus.pos_edge = 1'b0;
    idle(1);
    bus.wrt = 1'b0;
    chk("busy_during_ignored_wrt", bus.busy, 1'b1);
    waitDone(1000, "b2b_first");
    chk("done_cycle_seen", bus.done, 1'b1);
    sendWord(16'h00F0, 1'b0, 1'b1, 16'h00F0, 340);
    waitDone(1000, "b2b_second");
    idle(3);

    // Synchronous reset mid-transfer aborts the word without a done pulse.
    sendWord(16'hBEEF, 1'b0, 1'b0, 16'hBEEF, 340);
    idle(100);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chkResetPins("abort");
    expQ.delete();
    start = doneCount;
    idle(400);
    chk("no_done_after_abort", doneCount - start, 0);
    sendWord(16'h1234, 1'b0, 1'b1, 16'h1234, 340);
    waitDone(1000, "after_abort");
    idle(5);
    chk("scoreboard_empty", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
